vrf_write_scheduler: RTL and testbench

Write-port scheduler for the 4 × 512-bit vector register file. Arbitrates up to NREQ requesters (memory load unit, ALU result path, host/debug) onto the file's two write ports: round-robin fairness, packing of two single writes into one cycle, and a two-cycle hardware clear sequence. Sits between the execution units and the register file's data_in_1/2, w_reg_1/2 and w_enable_1/2 inputs.

---
 rtl/vrf_write_scheduler_if.sv | 45 ++++
 rtl/vrf_write_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_vrf_write_scheduler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_write_scheduler_if.sv
// Request/write-port bundle between the execution units, the write scheduler and the register file.
// Pure wiring: no storage, no latency.
// Backpressure is carried by req_ready; the register-file side never stalls.
interface vrf_write_scheduler_if #(
  parameter int NREQ = 3,
  parameter int W    = 512
);
  // Requester side: per-requester fields packed side by side, requester i at slice i
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_dual;
  logic [2*NREQ-1:0] req_reg_a;
  logic [2*NREQ-1:0] req_reg_b;
  logic [W*NREQ-1:0] req_data_a;
  logic [W*NREQ-1:0] req_data_b;
  logic [NREQ-1:0]   req_ready;

  // Control
  logic              hold;
  logic              clr_req;
  logic              clr_busy;

  // Register-file write ports
  logic              w_enable_1;
  logic              w_enable_2;
  logic [1:0]        w_reg_1;
  logic [1:0]        w_reg_2;
  logic [W-1:0]      data_in_1;
  logic [W-1:0]      data_in_2;

  // Driver of requests and consumer of the write ports
  modport master (
    output req_valid, req_dual, req_reg_a, req_reg_b, req_data_a, req_data_b,
    output hold, clr_req,
    input  req_ready, clr_busy,
    input  w_enable_1, w_enable_2, w_reg_1, w_reg_2, data_in_1, data_in_2
  );

  // The scheduler itself
  modport slave (
    input  req_valid, req_dual, req_reg_a, req_reg_b, req_data_a, req_data_b,
    input  hold, clr_req,
    output req_ready, clr_busy,
    output w_enable_1, w_enable_2, w_reg_1, w_reg_2, data_in_1, data_in_2
  );
endinterface

// File: rtl/vrf_write_scheduler.sv
// Round-robin scheduler of NREQ requesters onto the two register-file write ports, with pair packing and a 2-cycle clear.
// Latency: grant is combinational; port outputs are registered at the handshake edge (clear writes follow clr_req by 1 and 2 cycles).
// Backpressure: req_ready drops during hold, clr_req, the clear sequence and reset; the register file itself never stalls.
module vrf_write_scheduler #(
  parameter int NREQ = 3,
  parameter int W    = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  vrf_write_scheduler_if.slave bus
);

  localparam int RW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR0 = 2'd1,
    CLR1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] rr;
  logic [RW-1:0] rr_nxt;

  // Arbitration result for the current cycle (valid only when issuing is allowed)
  logic [NREQ-1:0] arb_grant;
  logic            arb_en1;
  logic            arb_en2;
  logic [1:0]      arb_reg1;
  logic [1:0]      arb_reg2;
  logic [W-1:0]    arb_dat1;
  logic [W-1:0]    arb_dat2;
  logic [RW-1:0]   arb_last;

  // Values the port registers take at the next edge
  logic [NREQ-1:0] ready_int;
  logic            nxt_en1;
  logic            nxt_en2;
  logic [1:0]      nxt_reg1;
  logic [1:0]      nxt_reg2;
  logic [W-1:0]    nxt_dat1;
  logic [W-1:0]    nxt_dat2;

  // Round-robin scan from rr: first valid requester owns port1; a lone single write may be paired with a later
  // single to a different register, while a dual write occupies both ports (or port1 alone when a == b).
  always_comb begin
    int  idx;
    logic have_pri;
    logic pair_open;
    arb_grant = '0;
    arb_en1   = 1'b0;
    arb_en2   = 1'b0;
    arb_reg1  = 2'd0;
    arb_reg2  = 2'd0;
    arb_dat1  = '0;
    arb_dat2  = '0;
    arb_last  = rr;
    have_pri  = 1'b0;
    pair_open = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!have_pri) begin
        if (bus.req_valid[idx]) begin
          have_pri       = 1'b1;
          arb_grant[idx] = 1'b1;
          arb_last       = RW'(idx);
          arb_en1        = 1'b1;
          arb_reg1       = bus.req_reg_a[2*idx +: 2];
          if (bus.req_dual[idx]) begin
            if (bus.req_reg_a[2*idx +: 2] != bus.req_reg_b[2*idx +: 2]) begin
              arb_dat1 = bus.req_data_a[W*idx +: W];
              arb_en2  = 1'b1;
              arb_reg2 = bus.req_reg_b[2*idx +: 2];
              arb_dat2 = bus.req_data_b[W*idx +: W];
            end else begin
              // Both halves hit one register: the b write is the one that would land last, so it wins
              arb_dat1 = bus.req_data_b[W*idx +: W];
            end
          end else begin
            arb_dat1  = bus.req_data_a[W*idx +: W];
            pair_open = 1'b1;
          end
        end
      end else if (pair_open && bus.req_valid[idx] && !bus.req_dual[idx] &&
                   (bus.req_reg_a[2*idx +: 2] != arb_reg1)) begin
        arb_grant[idx] = 1'b1;
        arb_last       = RW'(idx);
        arb_en2        = 1'b1;
        arb_reg2       = bus.req_reg_a[2*idx +: 2];
        arb_dat2       = bus.req_data_a[W*idx +: W];
        pair_open      = 1'b0;
      end
    end
  end

  // Next state, grants and next port values; addresses and data hold when a port is idle
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    ready_int = '0;
    nxt_en1   = 1'b0;
    nxt_en2   = 1'b0;
    nxt_reg1  = bus.w_reg_1;
    nxt_reg2  = bus.w_reg_2;
    nxt_dat1  = bus.data_in_1;
    nxt_dat2  = bus.data_in_2;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLR0;
        end else if (!bus.hold) begin
          ready_int = arb_grant;
          if (arb_en1) begin
            nxt_en1  = 1'b1;
            nxt_reg1 = arb_reg1;
            nxt_dat1 = arb_dat1;
          end
          if (arb_en2) begin
            nxt_en2  = 1'b1;
            nxt_reg2 = arb_reg2;
            nxt_dat2 = arb_dat2;
          end
          if (|arb_grant) begin
            rr_nxt = (arb_last == RW'(NREQ - 1)) ? '0 : arb_last + 1'b1;
          end
        end
      end
      CLR0: begin
        state_nxt = CLR1;
        nxt_en1   = 1'b1;
        nxt_en2   = 1'b1;
        nxt_reg1  = 2'd0;
        nxt_reg2  = 2'd1;
        nxt_dat1  = '0;
        nxt_dat2  = '0;
      end
      CLR1: begin
        state_nxt = IDLE;
        nxt_en1   = 1'b1;
        nxt_en2   = 1'b1;
        nxt_reg1  = 2'd2;
        nxt_reg2  = 2'd3;
        nxt_dat1  = '0;
        nxt_dat2  = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grants are withheld while reset is asserted so nothing is consumed that will not be written
  assign bus.req_ready = reset ? '0 : ready_int;
  assign bus.clr_busy  = (state != IDLE);

  // State and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // Registered write-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.w_enable_1 <= 1'b0;
      bus.w_enable_2 <= 1'b0;
      bus.w_reg_1    <= 2'd0;
      bus.w_reg_2    <= 2'd0;
      bus.data_in_1  <= '0;
      bus.data_in_2  <= '0;
    end else begin
      bus.w_enable_1 <= nxt_en1;
      bus.w_enable_2 <= nxt_en2;
      bus.w_reg_1    <= nxt_reg1;
      bus.w_reg_2    <= nxt_reg2;
      bus.data_in_1  <= nxt_dat1;
      bus.data_in_2  <= nxt_dat2;
    end
  end

endmodule

// File: tb/tb_vrf_write_scheduler.sv
// Bench for vrf_write_scheduler: directed scenarios followed by random traffic, all checked against a reference model.
// Every cycle compares req_ready before the edge and all port outputs after it.
// Requests are held until the model grants them, then retired.
module tb_vrf_write_scheduler;
  localparam int NREQ = 3;
  localparam int W    = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vrf_write_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();
  vrf_write_scheduler #(.NREQ(NREQ), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Requester stimulus state
  logic         rv  [NREQ];
  logic         rdl [NREQ];
  logic [1:0]   ra  [NREQ];
  logic [1:0]   rb  [NREQ];
  logic [W-1:0] da  [NREQ];
  logic [W-1:0] db  [NREQ];
  logic         hold_i;
  logic         clr_i;

  int total = 0;
  int bad   = 0;

  // Reference model state: 0 idle, 1 first clear cycle, 2 second clear cycle
  int           m_state, n_state;
  int           m_rr, n_rr;
  logic         m_en1, m_en2, n_en1, n_en2;
  logic [1:0]   m_r1, m_r2, n_r1, n_r2;
  logic [W-1:0] m_d1, m_d2, n_d1, n_d2;
  logic [NREQ-1:0] e_ready;
  logic [NREQ-1:0] obs_ready;
  logic [NREQ-1:0] exp_ord;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = rv[i];
      bus.req_dual[i]            = rdl[i];
      bus.req_reg_a[2*i +: 2]    = ra[i];
      bus.req_reg_b[2*i +: 2]    = rb[i];
      bus.req_data_a[W*i +: W]   = da[i];
      bus.req_data_b[W*i +: W]   = db[i];
    end
    bus.hold    = hold_i;
    bus.clr_req = clr_i;
  endtask

  // Grant set and next port values straight from the scheduling rules
  task automatic model_step();
    int ord [NREQ];
    int p, pi, q, last;
    e_ready = '0;
    n_en1 = 1'b0; n_en2 = 1'b0;
    n_r1 = m_r1; n_r2 = m_r2; n_d1 = m_d1; n_d2 = m_d2;
    n_state = m_state; n_rr = m_rr;
    if (reset) begin
      n_state = 0; n_rr = 0;
      n_r1 = 2'd0; n_r2 = 2'd0; n_d1 = '0; n_d2 = '0;
    end else if (m_state == 1) begin
      n_state = 2; n_en1 = 1'b1; n_en2 = 1'b1;
      n_r1 = 2'd0; n_r2 = 2'd1; n_d1 = '0; n_d2 = '0;
    end else if (m_state == 2) begin
      n_state = 0; n_en1 = 1'b1; n_en2 = 1'b1;
      n_r1 = 2'd2; n_r2 = 2'd3; n_d1 = '0; n_d2 = '0;
    end else if (clr_i) begin
      n_state = 1;
    end else if (!hold_i) begin
      for (int k = 0; k < NREQ; k++) ord[k] = (m_rr + k) % NREQ;
      p = -1;
      for (int k = 0; k < NREQ; k++) if (p < 0 && rv[ord[k]]) p = k;
      if (p >= 0) begin
        pi = ord[p];
        e_ready[pi] = 1'b1;
        last = pi;
        n_en1 = 1'b1;
        n_r1 = ra[pi];
        if (rdl[pi]) begin
          if (ra[pi] != rb[pi]) begin
            n_d1 = da[pi]; n_en2 = 1'b1; n_r2 = rb[pi]; n_d2 = db[pi];
          end else begin
            n_d1 = db[pi];
          end
        end else begin
          n_d1 = da[pi];
          q = -1;
          for (int k = p + 1; k < NREQ; k++)
            if (q < 0 && rv[ord[k]] && !rdl[ord[k]] && ra[ord[k]] != ra[pi]) q = ord[k];
          if (q >= 0) begin
            e_ready[q] = 1'b1; n_en2 = 1'b1; n_r2 = ra[q]; n_d2 = da[q]; last = q;
          end
        end
        n_rr = (last + 1) % NREQ;
      end
    end
  endtask

  // One clock: check grants before the edge, outputs after it, retire granted requests
  task automatic cycle();
    drive();
    #1;
    model_step();
    obs_ready = bus.req_ready;
    chk("ready", W'(obs_ready), W'(e_ready));
    @(posedge clk);
    #1;
    m_state = n_state; m_rr = n_rr;
    m_en1 = n_en1; m_en2 = n_en2; m_r1 = n_r1; m_r2 = n_r2; m_d1 = n_d1; m_d2 = n_d2;
    chk("w_enable_1", W'(bus.w_enable_1), W'(m_en1));
    chk("w_enable_2", W'(bus.w_enable_2), W'(m_en2));
    chk("w_reg_1", W'(bus.w_reg_1), W'(m_r1));
    chk("w_reg_2", W'(bus.w_reg_2), W'(m_r2));
    chk("data_in_1", bus.data_in_1, m_d1);
    chk("data_in_2", bus.data_in_2, m_d2);
    chk("clr_busy", W'(bus.clr_busy), W'(m_state != 0));
    for (int i = 0; i < NREQ; i++) if (e_ready[i]) rv[i] = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic set_req(input int i, input logic d, input logic [1:0] a, input logic [1:0] b);
    rv[i] = 1'b1; rdl[i] = d; ra[i] = a; rb[i] = b;
    da[i] = {16{$urandom()}}; db[i] = {16{$urandom()}};
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      rv[i] = 1'b0; rdl[i] = 1'b0; ra[i] = 2'd0; rb[i] = 2'd0; da[i] = '0; db[i] = '0;
    end
    hold_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pat;
    pat = {64{8'hA5}};
    m_state = 0; m_rr = 0; m_en1 = 0; m_en2 = 0; m_r1 = 0; m_r2 = 0; m_d1 = '0; m_d2 = '0;
    clear_all();
    reset = 1'b1;
    cycle();
    cycle();
    chk("reset_en1", W'(bus.w_enable_1), W'(0));
    chk("reset_data1", bus.data_in_1, '0);
    reset = 1'b0;

    // Single write from requester 0
    set_req(0, 1'b0, 2'd2, 2'd0);
    da[0] = pat;
    cycle();
    chk("t1_ready", W'(obs_ready), W'(3'b001));
    chk("t1_en1", W'(bus.w_enable_1), W'(1));
    chk("t1_reg1", W'(bus.w_reg_1), W'(2));
    chk("t1_data1", bus.data_in_1, pat);
    chk("t1_en2", W'(bus.w_enable_2), W'(0));

    // Two singles to different registers pack into one cycle
    do_reset();
    set_req(0, 1'b0, 2'd1, 2'd0);
    set_req(1, 1'b0, 2'd3, 2'd0);
    cycle();
    chk("t2_ready", W'(obs_ready), W'(3'b011));
    chk("t2_reg1", W'(bus.w_reg_1), W'(1));
    chk("t2_reg2", W'(bus.w_reg_2), W'(3));
    chk("t2_data2", bus.data_in_2, da[1]);

    // Same register: serialised
    do_reset();
    set_req(0, 1'b0, 2'd1, 2'd0);
    set_req(1, 1'b0, 2'd1, 2'd0);
    cycle();
    chk("t2s_first", W'(obs_ready), W'(3'b001));
    chk("t2s_en2", W'(bus.w_enable_2), W'(0));
    cycle();
    chk("t2s_second", W'(obs_ready), W'(3'b010));

    // Dual write with rr=1 takes both ports, the single waits
    do_reset();
    set_req(0, 1'b0, 2'd0, 2'd0);
    cycle();
    set_req(1, 1'b1, 2'd0, 2'd2);
    set_req(0, 1'b0, 2'd1, 2'd0);
    cycle();
    chk("t3_ready", W'(obs_ready), W'(3'b010));
    chk("t3_reg1", W'(bus.w_reg_1), W'(0));
    chk("t3_reg2", W'(bus.w_reg_2), W'(2));
    chk("t3_data1", bus.data_in_1, da[1]);
    chk("t3_data2", bus.data_in_2, db[1]);
    cycle();
    chk("t3_single", W'(obs_ready), W'(3'b001));
    set_req(2, 1'b1, 2'd3, 2'd3);
    cycle();
    chk("t3c_en1", W'(bus.w_enable_1), W'(1));
    chk("t3c_en2", W'(bus.w_enable_2), W'(0));
    chk("t3c_reg1", W'(bus.w_reg_1), W'(3));
    chk("t3c_data1", bus.data_in_1, db[2]);

    // Fairness under continuous contention for one register
    do_reset();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) if (!rv[i]) set_req(i, 1'b0, 2'd1, 2'd0);
      cycle();
      exp_ord = 3'b001 << (n % 3);
      chk("t4_order", W'(obs_ready), W'(exp_ord));
    end

    // Clear sequence while requesters are waiting
    do_reset();
    set_req(0, 1'b0, 2'd1, 2'd0);
    set_req(1, 1'b0, 2'd2, 2'd0);
    clr_i = 1'b1;
    cycle();
    chk("t5_ready0", W'(obs_ready), W'(0));
    chk("t5_busy0", W'(bus.clr_busy), W'(1));
    chk("t5_en_pulse", W'(bus.w_enable_1), W'(0));
    cycle();
    chk("t5_ready1", W'(obs_ready), W'(0));
    chk("t5_pair01", W'({bus.w_enable_1, bus.w_enable_2, bus.w_reg_1, bus.w_reg_2}), W'(6'b11_00_01));
    chk("t5_zero1", bus.data_in_1, '0);
    chk("t5_busy1", W'(bus.clr_busy), W'(1));
    cycle();
    chk("t5_ready2", W'(obs_ready), W'(0));
    chk("t5_pair23", W'({bus.w_enable_1, bus.w_enable_2, bus.w_reg_1, bus.w_reg_2}), W'(6'b11_10_11));
    chk("t5_zero2", bus.data_in_2, '0);
    chk("t5_busy2", W'(bus.clr_busy), W'(0));
    cycle();
    chk("t5_resume", W'(obs_ready), W'(3'b011));

    // Reset during the first clear cycle abandons the sequence
    do_reset();
    clear_all();
    clr_i = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5r_en1", W'(bus.w_enable_1), W'(0));
    chk("t5r_busy", W'(bus.clr_busy), W'(0));
    cycle();
    chk("t5r_no_clr1", W'({bus.w_enable_1, bus.w_enable_2}), W'(0));

    // Hold suppresses issue for exactly that cycle
    do_reset();
    set_req(2, 1'b0, 2'd2, 2'd0);
    hold_i = 1'b1;
    cycle();
    chk("t6_hold_ready", W'(obs_ready), W'(0));
    chk("t6_hold_en", W'(bus.w_enable_1), W'(0));
    hold_i = 1'b0;
    cycle();
    chk("t6_ready", W'(obs_ready), W'(3'b100));
    chk("t6_reg1", W'(bus.w_reg_1), W'(2));

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rv[i] && ($urandom % 3) == 0)
          set_req(i, 1'($urandom % 2), 2'($urandom % 4), 2'($urandom % 4));
      hold_i = (($urandom % 10) == 0);
      clr_i  = (($urandom % 25) == 0);
      reset  = (($urandom % 100) == 0);
      cycle();
      reset  = 1'b0;
      hold_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
